// File: rtl/ysyx_23060208_clint_if.sv
`default_nettype none
// ============================================================================
// ysyx_23060208_clint_if : AXI-lite bus bundle between the EXU arbiter and CLINT
// Revision: 1.0
// ============================================================================
interface ysyx_23060208_clint_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] clint_araddr;
    logic                  clint_arvalid;
    logic                  clint_arready;
    logic [DATA_WIDTH-1:0] clint_rdata;
    logic [1:0]            clint_rresp;
    logic                  clint_rvalid;
    logic                  clint_rready;
    logic [DATA_WIDTH-1:0] clint_awaddr;
    logic                  clint_awvalid;
    logic                  clint_awready;
    logic [DATA_WIDTH-1:0] clint_wdata;
    logic [2:0]            clint_wstrb;
    logic                  clint_wvalid;
    logic                  clint_wready;
    logic [1:0]            clint_bresp;
    logic                  clint_bvalid;
    logic                  clint_bready;

    modport master (
        output clint_araddr, clint_arvalid, clint_rready,
        output clint_awaddr, clint_awvalid, clint_wdata, clint_wstrb, clint_wvalid, clint_bready,
        input  clint_arready, clint_rdata, clint_rresp, clint_rvalid,
        input  clint_awready, clint_wready, clint_bresp, clint_bvalid
    );

    modport slave (
        input  clint_araddr, clint_arvalid, clint_rready,
        input  clint_awaddr, clint_awvalid, clint_wdata, clint_wstrb, clint_wvalid, clint_bready,
        output clint_arready, clint_rdata, clint_rresp, clint_rvalid,
        output clint_awready, clint_wready, clint_bresp, clint_bvalid
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060208_clint.sv
`default_nettype none
// ============================================================================
// ysyx_23060208_clint : read-only 64-bit mtime responder, writes get SLVERR
// Revision: 1.0
// ============================================================================
module ysyx_23060208_clint #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'ha000_0048,
    parameter int          TICK_DIV   = 1
) (
    input  wire                  clk,
    input  wire                  rst,
    ysyx_23060208_clint_if.slave bus
);
    localparam int                    c_DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIV_W-1:0]    c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] c_LO_ADDR  = DATA_WIDTH'(BASE_ADDR);
    localparam logic [DATA_WIDTH-1:0] c_HI_ADDR  = DATA_WIDTH'(BASE_ADDR + 32'd4);
    localparam logic [0:0]            c_R_IDLE   = 1'b0;
    localparam logic [0:0]            c_R_RESP   = 1'b1;
    localparam logic [0:0]            c_W_IDLE   = 1'b0;
    localparam logic [0:0]            c_W_RESP   = 1'b1;

    logic [63:0]           r_mtime;
    logic [c_DIV_W-1:0]    r_div_cnt;
    logic [31:0]           r_hi_snap;
    logic [0:0]            r_rstate;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [0:0]            r_wstate;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [1:0]            r_bresp;

    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_seen;
    logic w_w_seen;
    logic w_unused;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_mtime   <= '0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            r_mtime   <= r_mtime + 64'd1;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    assign w_ar_hs = bus.clint_arvalid & (r_rstate == c_R_IDLE);
    assign w_r_hs  = bus.clint_rready  & (r_rstate == c_R_RESP);

    // A low-word read latches the high word so the following high read is coherent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate  <= c_R_IDLE;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_hi_snap <= '0;
        end else if (w_ar_hs) begin
            r_rstate <= c_R_RESP;
            if (bus.clint_araddr[DATA_WIDTH-1:2] == c_LO_ADDR[DATA_WIDTH-1:2]) begin
                r_rdata   <= DATA_WIDTH'(r_mtime[31:0]);
                r_rresp   <= 2'b00;
                r_hi_snap <= r_mtime[63:32];
            end else if (bus.clint_araddr[DATA_WIDTH-1:2] == c_HI_ADDR[DATA_WIDTH-1:2]) begin
                r_rdata <= DATA_WIDTH'(r_hi_snap);
                r_rresp <= 2'b00;
            end else begin
                r_rdata <= '0;
                r_rresp <= 2'b10;
            end
        end else if (w_r_hs) begin
            r_rstate <= c_R_IDLE;
        end
    end

    assign bus.clint_arready = (r_rstate == c_R_IDLE);
    assign bus.clint_rvalid  = (r_rstate == c_R_RESP);
    assign bus.clint_rdata   = r_rdata;
    assign bus.clint_rresp   = r_rresp;

    assign w_aw_hs   = bus.clint_awvalid & bus.clint_awready;
    assign w_w_hs    = bus.clint_wvalid  & bus.clint_wready;
    assign w_aw_seen = r_aw_done | w_aw_hs;
    assign w_w_seen  = r_w_done  | w_w_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate  <= c_W_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bresp   <= 2'b00;
        end else if (r_wstate == c_W_IDLE) begin
            if (w_aw_seen && w_w_seen) begin
                r_wstate  <= c_W_RESP;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_bresp   <= 2'b10;
            end else begin
                r_aw_done <= w_aw_seen;
                r_w_done  <= w_w_seen;
            end
        end else if (bus.clint_bready) begin
            r_wstate <= c_W_IDLE;
        end
    end

    assign bus.clint_awready = (r_wstate == c_W_IDLE) & ~r_aw_done;
    assign bus.clint_wready  = (r_wstate == c_W_IDLE) & ~r_w_done;
    assign bus.clint_bvalid  = (r_wstate == c_W_RESP);
    assign bus.clint_bresp   = r_bresp;

    // Write payload and byte offset carry no meaning for this timer.
    assign w_unused = ^{bus.clint_awaddr, bus.clint_wdata, bus.clint_wstrb, bus.clint_araddr[1:0]};
endmodule
`default_nettype wire

// File: doc/ysyx_23060208_clint.md
# ysyx_23060208_clint

Memory-mapped machine-timer responder on the data-side bus, the read-direction counterpart of the write-only UART responder. It keeps a free-running 64-bit `mtime` counter and returns it over AXI-lite read transactions routed by the arbiter from the EXU. Writes are accepted and answered with an error response. Reads of the low word snapshot the high word, so software always sees a consistent 64-bit value.

## Interface
- `DATA_WIDTH`, 32, bus data and address width.
- `BASE_ADDR`, 32'ha000_0048, address of the `mtime` low word. The high word is at `BASE_ADDR+4`.
- `TICK_DIV`, 1, clock cycles per `mtime` increment. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `clint_araddr`  in  DATA_WIDTH  read address.
- `clint_arvalid`  in  1  read address valid.
- `clint_arready`  out  1  read address ready.
- `clint_rdata`  out  DATA_WIDTH  read data.
- `clint_rresp`  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- `clint_rvalid`  out  1  read data valid.
- `clint_rready`  in  1  read data ready.
- `clint_awaddr`  in  DATA_WIDTH  write address (ignored apart from the handshake).
- `clint_awvalid`  in  1  write address valid.
- `clint_awready`  out  1  write address ready.
- `clint_wdata`  in  DATA_WIDTH  write data (ignored).
- `clint_wstrb`  in  3  write strobe (ignored).
- `clint_wvalid`  in  1  write data valid.
- `clint_wready`  out  1  write data ready.
- `clint_bresp`  out  2  write response; always 2'b10.
- `clint_bvalid`  out  1  write response valid.
- `clint_bready`  in  1  write response ready.

## Operation

**Timer**
- 64-bit `mtime` register and prescaler `div_cnt` (width `$clog2(TICK_DIV)`, minimum 1).
- Each cycle:
  - If `div_cnt == TICK_DIV-1`: set `div_cnt` to 0 and increment `mtime` by 1.
  - Otherwise: increment `div_cnt`.
- `TICK_DIV=1`: `mtime` increments every cycle.
- `mtime` wraps from 2^64-1 to 0 silently.

**Read FSM** (states R_IDLE, R_RESP)
- R_IDLE, `arvalid & arready` → R_RESP. Capture:
  - `araddr[31:2] == BASE_ADDR[31:2]`: `rdata = mtime[31:0]`, `rresp = 00`, and load `hi_snap` with `mtime[63:32]`.
  - `araddr[31:2] == (BASE_ADDR+4)[31:2]`: `rdata = hi_snap`, `rresp = 00`.
  - Any other address: `rdata = 0`, `rresp = 10`.
  - `araddr[1:0]` is ignored.
- R_RESP, `rvalid & rready` → R_IDLE.
- `arready = (state == R_IDLE)`, driven combinationally from registered state.
- Values are taken from register contents before the capture edge. An increment on the same edge is not visible in that read.
- A high-word read with no prior low-word read returns the reset value of `hi_snap` (0).

**Write FSM** (states W_IDLE, W_RESP)
- In W_IDLE:
  - `awready` is 1 until AW is accepted.
  - `wready` is 1 until W is accepted.
  - AW and W may arrive in either order or in the same cycle; each acceptance is recorded in a flag.
  - When both flags are set (including when they set on the same edge), go to W_RESP and clear both flags.
- In W_RESP: `bvalid = 1`, `bresp = 10`, `awready = wready = 0`.
- On `bvalid & bready`: return to W_IDLE.
- Writes never modify `mtime`.
- The read and write FSMs are independent and may be active in the same cycle.

## Timing
- Reset values:
  - `mtime`, `div_cnt`, `hi_snap` = 0.
  - Read FSM in R_IDLE: `arready = 1`, `rvalid = 0`, `rdata = 0`, `rresp = 00`.
  - Write FSM in W_IDLE: `awready = wready = 1`, `bvalid = 0`, `bresp = 00`.
- Read latency:
  - AR handshake on edge T; `rvalid = 1` from T+1.
  - `rvalid`, `rdata` and `rresp` stay stable until the `rready` handshake.
  - Next AR is accepted no earlier than the cycle after the R handshake.
  - Maximum throughput is one read per 2 cycles.
- Write latency: `bvalid` rises the cycle after the later of the AW/W handshakes, and stays high until `bready`.
- AXI rule: `rvalid` and `bvalid` never drop without the corresponding ready.
- Reset asserted mid-transaction: all state clears immediately and asynchronously. Any pending response is dropped, and `mtime` restarts from 0.
- After reset release, the first `mtime` increment occurs on the `TICK_DIV`-th rising edge.

## Test plan
- Reset release, `TICK_DIV=1`; read `BASE_ADDR` with `arvalid` held, `rready = 1` → handshake on edge 3 returns `rdata = 2`, `rresp = 00`, `rvalid` for exactly 1 cycle.
- Force `mtime` to 64'h0000_0001_FFFF_FFFF; read low then high → low returns 32'hFFFF_FFFF, high returns 32'h1 (the snapshot, not 2).
- `TICK_DIV=4`: hold `rready = 0` for 10 cycles during a read → `rvalid` and `rdata` stay stable; `mtime` advances exactly once every 4 cycles.
- Read `BASE_ADDR+8` → `rdata = 0`, `rresp = 10`. A following `BASE_ADDR` read still returns OKAY.
- Write with AW two cycles before W, then AW and W in the same cycle, each with `bready = 0` for 3 cycles → each gives one `bvalid` pulse held until `bready`, `bresp = 10`, and `mtime` is unchanged.
- Assert `rst = 0` while `rvalid = 1` → `rvalid = 0` and `mtime = 0` immediately. After release, `arready = 1` and a new read returns the fresh count.
